// File: rtl/frame_tx_pkg.sv
// Shared types and constants for the frame transmit scheduler.
// Frame layout: SYNC0, SYNC1, DEPTH words (low byte first), then one checksum byte.
package frame_tx_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_FETCH,
    S_WAIT,
    S_LO,
    S_HI,
    S_CSUM,
    S_DONE
  } state_e;

  localparam logic [7:0] SYNC0_DEFAULT = 8'hA5;
  localparam logic [7:0] SYNC1_DEFAULT = 8'h5A;

  // Total bytes on the wire for one frame of 'depth' 16-bit words.
  function automatic int unsigned frame_bytes(input int unsigned depth);
    return 2 + 2 * depth + 1;
  endfunction

endpackage

// File: rtl/frame_tx_scheduler_rd_port_arbiter.sv
// Single read port arbiter for the frame buffer.
// The comparator has fixed priority; rvalid flags mark data returning one cycle after a grant.
module rd_port_arbiter #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              det_req,
  input  logic [ADDR_W-1:0] det_addr,
  input  logic              tx_rd,
  input  logic [ADDR_W-1:0] tx_addr,
  output logic              det_gnt,
  output logic              tx_gnt,
  output logic              det_rvalid,
  output logic              tx_rvalid,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr
);

  assign det_gnt  = det_req;
  assign tx_gnt   = tx_rd & ~det_req;
  assign mem_en   = det_gnt | tx_gnt;
  assign mem_addr = det_gnt ? det_addr : (tx_gnt ? tx_addr : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      det_rvalid <= 1'b0;
      tx_rvalid  <= 1'b0;
    end else begin
      det_rvalid <= det_gnt;
      tx_rvalid  <= tx_gnt;
    end
  end

endmodule

// File: rtl/frame_tx_scheduler.sv
// Frame transmit sequencer: streams header, buffer words and checksum to the UART,
// fetching each word through the shared read-port arbiter.
module frame_tx_scheduler
  import frame_tx_pkg::*;
#(
  parameter int         DEPTH  = 19200,
  parameter int         ADDR_W = 15,
  parameter logic [7:0] SYNC0  = SYNC0_DEFAULT,
  parameter logic [7:0] SYNC1  = SYNC1_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  input  logic              det_req,
  input  logic [ADDR_W-1:0] det_addr,
  output logic              det_gnt,
  output logic              det_rvalid,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  output state_e            dbg_state
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wa_q;
  logic [7:0]        csum_q;
  logic [15:0]       word_q;
  logic              abort_q;
  logic              tx_rd, tx_gnt, tx_rvalid;

  // UART handshake: a byte moves on any cycle with tx_valid & tx_ready; while
  // tx_valid is high and tx_ready low, tx_byte and tx_valid hold unchanged.
  logic xfer;
  logic abort_pend;
  logic last_word;

  assign xfer       = tx_valid & tx_ready;
  assign abort_pend = abort_q | abort;
  assign last_word  = (wa_q == ADDR_W'(DEPTH - 1));
  assign busy       = (state_q != S_IDLE);
  assign dbg_state  = state_q;

  rd_port_arbiter #(.ADDR_W(ADDR_W)) u_arb (
    .clk        (clk),
    .reset_n    (reset_n),
    .det_req    (det_req),
    .det_addr   (det_addr),
    .tx_rd      (tx_rd),
    .tx_addr    (wa_q),
    .det_gnt    (det_gnt),
    .tx_gnt     (tx_gnt),
    .det_rvalid (det_rvalid),
    .tx_rvalid  (tx_rvalid),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr)
  );

  always_comb begin
    state_d  = state_q;
    tx_valid = 1'b0;
    tx_byte  = 8'h00;
    tx_rd    = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: if (start && !abort) state_d = S_HDR0;
      S_HDR0: begin
        tx_valid = 1'b1;
        tx_byte  = SYNC0;
        if (xfer) state_d = abort_pend ? S_IDLE : S_HDR1;
      end
      S_HDR1: begin
        tx_valid = 1'b1;
        tx_byte  = SYNC1;
        if (xfer) state_d = abort_pend ? S_IDLE : S_FETCH;
      end
      S_FETCH: begin
        if (abort_pend) state_d = S_IDLE;
        else begin
          tx_rd = 1'b1;
          if (tx_gnt) state_d = S_WAIT;
        end
      end
      // An abort here drops the outstanding read; its rvalid is simply ignored.
      S_WAIT: begin
        if (abort_pend) state_d = S_IDLE;
        else if (tx_rvalid) state_d = S_LO;
      end
      S_LO: begin
        tx_valid = 1'b1;
        tx_byte  = word_q[7:0];
        if (xfer) state_d = abort_pend ? S_IDLE : S_HI;
      end
      S_HI: begin
        tx_valid = 1'b1;
        tx_byte  = word_q[15:8];
        if (xfer) state_d = abort_pend ? S_IDLE : (last_word ? S_CSUM : S_FETCH);
      end
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_byte  = csum_q;
        if (xfer) state_d = abort_pend ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        if (abort_pend) state_d = S_IDLE;
        else begin
          done    = 1'b1;
          state_d = continuous ? S_HDR0 : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wa_q    <= '0;
      csum_q  <= 8'h00;
      word_q  <= 16'h0000;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_IDLE) abort_q <= 1'b0;
      else if (abort)        abort_q <= 1'b1;
      if (state_d == S_HDR0 && (state_q == S_IDLE || state_q == S_DONE)) begin
        wa_q   <= '0;
        csum_q <= 8'h00;
      end
      if (state_q == S_WAIT && state_d == S_LO) word_q <= mem_rdata;
      if (state_q == S_LO && xfer) csum_q <= csum_q + word_q[7:0];
      if (state_q == S_HI && xfer) begin
        csum_q <= csum_q + word_q[15:8];
        if (!last_word) wa_q <= wa_q + ADDR_W'(1);
      end
    end
  end

endmodule
